// File: rtl/pipearch_dma_read_arbiter.sv
// pipearch_dma_read_arbiter
// Shares one AXI read DMA engine among NUM_CLIENTS requesters. A round-robin
// pick in IDLE accepts one transfer (start address + line count). The
// transfer is forwarded to the DMA in ISSUE. In DRAIN, every returned line is
// steered back to the owning client until the whole transfer is delivered.
//
// Ports:
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   req_valid/req_ready       per-client request handshake
//   req_addr/req_len          packed per-client start address / line count
//   rsp_valid/rsp_ready       per-client line handshake
//   rsp_data/rsp_last         shared line data, final-line marker
//   dma_req_*                 command channel to the DMA
//   dma_rsp_*                 line channel from the DMA
//   grant_id                  index of the current owner
//   busy                      high whenever the FSM is not in IDLE
module pipearch_dma_read_arbiter #(
   parameter int unsigned NUM_CLIENTS = 4,
   parameter int unsigned ADDR_WIDTH  = 42,
   parameter int unsigned LEN_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH  = 512,
   parameter int unsigned ID_WIDTH    = $clog2(NUM_CLIENTS)
) (
   input  logic                              ap_clk,
   input  logic                              ap_rst_n,
   input  logic [NUM_CLIENTS-1:0]            req_valid,
   output logic [NUM_CLIENTS-1:0]            req_ready,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_CLIENTS*LEN_WIDTH-1:0]  req_len,
   output logic [NUM_CLIENTS-1:0]            rsp_valid,
   input  logic [NUM_CLIENTS-1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0]             rsp_data,
   output logic                              rsp_last,
   output logic                              dma_req_valid,
   input  logic                              dma_req_ready,
   output logic [ADDR_WIDTH-1:0]             dma_req_addr,
   output logic [LEN_WIDTH-1:0]              dma_req_len,
   input  logic                              dma_rsp_valid,
   output logic                              dma_rsp_ready,
   input  logic [DATA_WIDTH-1:0]             dma_rsp_data,
   output logic [ID_WIDTH-1:0]               grant_id,
   output logic                              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [ID_WIDTH-1:0]   last_grant;
   logic [ID_WIDTH-1:0]   winner;
   logic [ID_WIDTH-1:0]   idx;
   logic                  found;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [LEN_WIDTH-1:0]  win_len;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  count;
   logic                  rsp_hs;
   logic                  last_line;

   // Round-robin search starting one past the previous owner, wrapping
   // modulo NUM_CLIENTS; the first requester found wins.
   always_comb begin
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      for (int unsigned i = 1; i <= NUM_CLIENTS; i++) begin
         idx = ID_WIDTH'((32'(last_grant) + i) % NUM_CLIENTS);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign win_addr = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_len  = req_len[winner*LEN_WIDTH +: LEN_WIDTH];

   // Gated by reset so a request seen while reset is held is not acked.
   assign accept    = (state == IDLE) && found && ap_rst_n;
   assign rsp_hs    = (state == DRAIN) && dma_rsp_valid && rsp_ready[grant_id];
   assign last_line = (count == len_q - LEN_WIDTH'(1));

   always_comb begin
      state_next    = state;
      req_ready     = '0;
      dma_req_valid = 1'b0;
      dma_req_addr  = '0;
      dma_req_len   = '0;
      rsp_valid     = '0;
      rsp_data      = '0;
      rsp_last      = 1'b0;
      dma_rsp_ready = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               req_ready[winner] = 1'b1;
               // Zero-length transfers are consumed here without a DMA command.
               if (win_len != '0) state_next = ISSUE;
            end
         end
         ISSUE: begin
            dma_req_valid = 1'b1;
            dma_req_addr  = addr_q;
            dma_req_len   = len_q;
            if (dma_req_ready) state_next = DRAIN;
         end
         DRAIN: begin
            rsp_valid[grant_id] = dma_rsp_valid;
            dma_rsp_ready       = rsp_ready[grant_id];
            rsp_data            = dma_rsp_data;
            rsp_last            = last_line;
            if (rsp_hs && last_line) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state      <= IDLE;
         last_grant <= ID_WIDTH'(NUM_CLIENTS - 1);
         grant_id   <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         count      <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  grant_id <= winner;
                  addr_q   <= win_addr;
                  len_q    <= win_len;
                  if (win_len == '0) last_grant <= winner;
               end
            end
            ISSUE: begin
               if (dma_req_ready) count <= '0;
            end
            DRAIN: begin
               if (rsp_hs) begin
                  count <= count + LEN_WIDTH'(1);
                  if (last_line) last_grant <= grant_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipearch_dma_read_arbiter.sv
// Directed bench for pipearch_dma_read_arbiter with a small DMA model and
// scoreboards of expected commands and expected lines.
module tb_pipearch_dma_read_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 42;
   localparam int unsigned LW = 32;
   localparam int unsigned DW = 512;
   localparam int unsigned IW = 2;

   logic            ap_clk = 1'b0;
   logic            ap_rst_n = 1'b0;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*LW-1:0] req_len;
   logic [DW-1:0]   rsp_data, dma_rsp_data;
   logic            rsp_last, dma_req_valid, dma_req_ready;
   logic            dma_rsp_valid, dma_rsp_ready, busy;
   logic [AW-1:0]   dma_req_addr;
   logic [LW-1:0]   dma_req_len;
   logic [IW-1:0]   grant_id;

   pipearch_dma_read_arbiter #(
      .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_last(rsp_last),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
      .dma_req_addr(dma_req_addr), .dma_req_len(dma_req_len),
      .dma_rsp_valid(dma_rsp_valid), .dma_rsp_ready(dma_rsp_ready),
      .dma_rsp_data(dma_rsp_data),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int unsigned   id;
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
   } cmd_t;

   typedef struct {
      int unsigned   id;
      logic [DW-1:0] data;
      logic          last;
   } line_t;

   cmd_t        exp_cmd[$];
   line_t       exp_line[$];
   int unsigned grant_log[$];
   int          n_checks = 0;
   int          n_err = 0;
   int unsigned req_cnt[N];

   // DMA model state
   logic          m_active;
   int unsigned   m_owner;
   logic [LW-1:0] m_len, m_sent;
   logic [31:0]   m_seq;
   int unsigned   stall, hold_cnt, dv_rises;
   logic          rr_toggle, spur;
   int unsigned   cyc, grant_cyc, lines_done;
   logic          done_prev, dv_prev;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_data(input logic [31:0] s);
      return {16{s}};
   endfunction

   task automatic push_cmd(input int unsigned id, input logic [AW-1:0] a, input logic [LW-1:0] l);
      cmd_t c;
      c.id = id; c.addr = a; c.len = l;
      exp_cmd.push_back(c);
   endtask

   task automatic push_line();
      line_t ln;
      ln.id = m_owner; ln.data = mk_data(m_seq); ln.last = (m_sent == m_len - 1);
      exp_line.push_back(ln);
   endtask

   task automatic drive_dma();
      dma_rsp_valid = m_active | spur;
      dma_rsp_data  = m_active ? mk_data(m_seq) : '0;
   endtask

   task automatic request(input int unsigned c, input logic [AW-1:0] a,
                          input logic [LW-1:0] l, input int unsigned cnt);
      req_addr[c*AW +: AW] = a;
      req_len[c*LW +: LW]  = l;
      req_cnt[c]           = cnt;
      req_valid[c]         = (cnt != 0);
   endtask

   // One clock: observe at the falling edge, update stimulus just after the rising edge.
   task automatic step();
      logic         cmd_hs, line_hs;
      logic [N-1:0] rr_seen;
      line_t        ln;
      @(negedge ap_clk);
      cmd_hs  = 1'b0;
      line_hs = 1'b0;
      rr_seen = req_ready;
      check("rsp_valid", rsp_valid, m_active ? (N'(1) << m_owner) : '0);
      check("dma_rsp_ready", dma_rsp_ready, m_active ? rsp_ready[m_owner] : 1'b0);
      check("rsp_last", rsp_last, m_active && (m_sent == m_len - 1));
      if (done_prev) check("busy_after_last", busy, 1'b0);
      if (m_active) check("busy_drain", busy, 1'b1);
      if (|req_ready) begin
         check("ready_onehot", $onehot(req_ready), 1'b1);
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               grant_log.push_back(i);
               grant_cyc = cyc;
               check("ready_has_valid", req_valid[i], 1'b1);
            end
         end
      end
      if (dma_req_valid && !dv_prev) begin
         dv_rises++;
         check("cmd_latency", cyc, grant_cyc + 1);
      end
      if (dma_req_valid) begin
         if (exp_cmd.size() == 0) check("cmd_unexpected", dma_req_valid, 1'b0);
         else begin
            check("cmd_id", grant_id, exp_cmd[0].id);
            check("cmd_addr", dma_req_addr, exp_cmd[0].addr);
            check("cmd_len", dma_req_len, exp_cmd[0].len);
            if (dma_req_ready) begin
               m_owner = exp_cmd[0].id;
               m_len   = exp_cmd[0].len;
               cmd_hs  = 1'b1;
               void'(exp_cmd.pop_front());
            end else begin
               hold_cnt++;
               if (stall != 0) stall--;
            end
         end
      end
      if (|(rsp_valid & rsp_ready)) begin
         if (exp_line.size() == 0) check("line_unexpected", rsp_valid & rsp_ready, '0);
         else begin
            ln = exp_line.pop_front();
            check("line_owner", rsp_valid & rsp_ready, N'(1) << ln.id);
            check("line_data", rsp_data, ln.data);
            check("line_last", rsp_last, ln.last);
            line_hs = 1'b1;
         end
      end
      dv_prev = dma_req_valid;
      @(posedge ap_clk);
      #1;
      cyc++;
      done_prev = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (rr_seen[i] && req_cnt[i] != 0) req_cnt[i]--;
         req_valid[i] = (req_cnt[i] != 0);
      end
      if (line_hs) begin
         lines_done++;
         m_sent++;
         if (m_sent == m_len) begin
            m_active  = 1'b0;
            done_prev = 1'b1;
         end else begin
            m_seq++;
            push_line();
         end
      end
      if (cmd_hs) begin
         m_active = 1'b1;
         m_sent   = '0;
         m_seq++;
         push_line();
      end
      dma_req_ready = (stall == 0);
      if (rr_toggle) rsp_ready = ~rsp_ready;
      drive_dma();
   endtask

   task automatic run_idle(input int unsigned max);
      int unsigned k = 0;
      while ((busy || (|req_valid) || exp_cmd.size() != 0 || m_active) && k < max) begin
         step();
         k++;
      end
      check("run_timeout", k < max, 1'b1);
      step();
   endtask

   task automatic run_grants(input int unsigned n, input int unsigned max);
      int unsigned k = 0;
      while (grant_log.size() < n && k < max) begin step(); k++; end
      check("grant_timeout", k < max, 1'b1);
   endtask

   task automatic run_lines(input int unsigned n, input int unsigned max);
      int unsigned k = 0;
      while (lines_done < n && k < max) begin step(); k++; end
      check("line_timeout", k < max, 1'b1);
   endtask

   task automatic do_reset();
      ap_rst_n  = 1'b0;
      rsp_ready = '0;
      rr_toggle = 1'b0;
      spur      = 1'b0;
      m_active  = 1'b0;
      drive_dma();
      req_valid = '0;
      for (int i = 0; i < N; i++) req_cnt[i] = 0;
      exp_cmd.delete();
      exp_line.delete();
      stall = 0;
      dma_req_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      check("rst_req_ready", req_ready, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rsp_data", rsp_data, '0);
      check("rst_rsp_last", rsp_last, 1'b0);
      check("rst_dma_req_valid", dma_req_valid, 1'b0);
      check("rst_dma_req_addr", dma_req_addr, '0);
      check("rst_dma_req_len", dma_req_len, '0);
      check("rst_dma_rsp_ready", dma_rsp_ready, 1'b0);
      check("rst_grant_id", grant_id, '0);
      check("rst_busy", busy, 1'b0);
      @(posedge ap_clk);
      #1;
      ap_rst_n   = 1'b1;
      rsp_ready  = '1;
      done_prev  = 1'b0;
      dv_prev    = 1'b0;
      grant_log.delete();
      lines_done = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      int unsigned cnt[N];
      req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
      dma_req_ready = 1'b1; m_active = 1'b0; m_owner = 0; m_len = '0; m_sent = '0;
      m_seq = 32'h1000_0000; stall = 0; hold_cnt = 0; dv_rises = 0;
      rr_toggle = 1'b0; spur = 1'b0; cyc = 0; grant_cyc = 0; lines_done = 0;
      done_prev = 1'b0; dv_prev = 1'b0;
      for (int i = 0; i < N; i++) req_cnt[i] = 0;
      drive_dma();

      // Reset state
      do_reset();

      // Single client, len 4
      request(1, 42'h1000, 4, 1);
      push_cmd(1, 42'h1000, 4);
      run_idle(100);
      check("t1_grants", grant_log.size(), 1);
      check("t1_grant0", grant_log[0], 1);
      check("t1_lines", lines_done, 4);

      // Simultaneous requests after reset, client 0 re-requests later
      do_reset();
      request(0, 42'h2000, 2, 1);
      request(2, 42'h3000, 2, 1);
      request(3, 42'h4000, 2, 1);
      push_cmd(0, 42'h2000, 2);
      push_cmd(2, 42'h3000, 2);
      push_cmd(3, 42'h4000, 2);
      push_cmd(0, 42'h2100, 2);
      run_grants(2, 100);
      request(0, 42'h2100, 2, 1);
      run_idle(200);
      check("t2_grants", grant_log.size(), 4);
      check("t2_g0", grant_log[0], 0);
      check("t2_g1", grant_log[1], 2);
      check("t2_g2", grant_log[2], 3);
      check("t2_g3", grant_log[3], 0);

      // Fairness under saturation
      do_reset();
      for (int c = 0; c < N; c++) request(c, 42'h10000 * (c + 1), 1, 10);
      for (int i = 0; i < 40; i++) push_cmd(i % N, 42'h10000 * ((i % N) + 1), 1);
      run_idle(1000);
      check("t3_grants", grant_log.size(), 40);
      for (int c = 0; c < N; c++) cnt[c] = 0;
      foreach (grant_log[i]) begin
         if (grant_log[i] < N) cnt[grant_log[i]]++;
         check("t3_order", grant_log[i], i % N);
      end
      for (int c = 0; c < N; c++) check("t3_count", cnt[c], 10);

      // Backpressure: stalled command, toggling owner ready, stray DMA valid
      base = lines_done;
      hold_cnt = 0;
      stall = 5;
      dma_req_ready = 1'b0;
      rr_toggle = 1'b1;
      spur = 1'b1;
      drive_dma();
      request(0, 42'h5000, 8, 1);
      push_cmd(0, 42'h5000, 8);
      run_idle(200);
      spur = 1'b0;
      rr_toggle = 1'b0;
      rsp_ready = '1;
      drive_dma();
      check("t4_hold", hold_cnt, 5);
      check("t4_lines", lines_done - base, 8);
      check("t4_left", exp_line.size(), 0);

      // Zero-length request followed by client 3
      base = grant_log.size();
      dv_rises = 0;
      request(2, 42'h6000, 0, 1);
      request(3, 42'h7000, 1, 1);
      push_cmd(3, 42'h7000, 1);
      run_idle(100);
      check("t5_grants", grant_log.size() - base, 2);
      check("t5_first", grant_log[base], 2);
      check("t5_second", grant_log[base + 1], 3);
      check("t5_cmds", dv_rises, 1);

      // Reset mid-drain after line 2 of 6
      request(1, 42'h8000, 6, 1);
      push_cmd(1, 42'h8000, 6);
      base = lines_done;
      run_lines(base + 2, 100);
      do_reset();
      request(0, 42'h9000, 1, 1);
      request(1, 42'h8000, 1, 1);
      push_cmd(0, 42'h9000, 1);
      push_cmd(1, 42'h8000, 1);
      run_idle(100);
      check("t6_grants", grant_log.size(), 2);
      check("t6_first", grant_log[0], 0);
      check("t6_second", grant_log[1], 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
